store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: store/load address width (>= 3).
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries, power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port st_valid, input, 1: CPU store request.
REQ-006 SHALL have port st_ready, output, 1: buffer can accept a store.
REQ-007 SHALL have port st_addr, input, ADDR_W: store byte address.
REQ-008 SHALL have port st_size, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port st_wdata, input, 32: store data, right-justified.
REQ-010 SHALL have port st_exc, output, 1: address-error flag for the current store request.
REQ-011 SHALL have port mem_req, output, 1: head entry valid toward memory.
REQ-012 SHALL have port mem_addr, output, ADDR_W: word address, low 2 bits always 0.
REQ-013 SHALL have port mem_wdata, output, 32: lane-replicated write data.
REQ-014 SHALL have port mem_byteen, output, 4: byte enables, bit i = byte lane i.
REQ-015 SHALL have port mem_ack, input, 1: memory accepted the head entry.
REQ-016 SHALL have port ld_addr, input, ADDR_W: load address for hazard check.
REQ-017 SHALL have port ld_hit, output, 1: a pending store overlaps the load word.
REQ-018 SHALL have port count, output, clog2(DEPTH)+1: occupied entries.
REQ-019 SHALL have port empty, output, 1: count == 0.

Function
REQ-020 SHALL drive st_ready = (count != DEPTH), combinationally, independent of st_valid and mem_ack.
REQ-021 SHALL assert st_exc combinationally when st_valid and (size 11, or size 01 with addr[0]=1, or size 10 with addr[1:0]!=00).
REQ-022 SHALL enqueue on the edge where st_valid & st_ready & ~st_exc; faulting stores SHALL never be enqueued.
REQ-023 SHALL compute the entry byteen: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-024 SHALL compute the entry data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-025 SHALL store the entry address as {st_addr[ADDR_W-1:2], 2'b00}.
REQ-026 SHALL drive mem_req = ~empty; mem_addr, mem_wdata and mem_byteen SHALL come from the head entry and be 0 when empty.
REQ-027 SHALL hold head outputs stable while mem_req is high until mem_ack is sampled high.
REQ-028 SHALL dequeue the head on the edge where mem_req & mem_ack; mem_ack while empty SHALL be ignored.
REQ-029 SHALL handle simultaneous enqueue and dequeue in one cycle: count unchanged, both pointers advance.
REQ-030 SHALL not enqueue when full, even if a dequeue occurs in that same cycle (no full-bypass).
REQ-031 SHALL wrap read/write pointers modulo DEPTH; order SHALL be strict FIFO.
REQ-032 SHALL assert ld_hit combinationally when any valid entry has word address == ld_addr[ADDR_W-1:2]; byte-lane overlap is not checked.
REQ-033 SHALL include the entry being dequeued in the ld_hit check for that cycle; the entry being enqueued is excluded.
REQ-034 SHALL update count with latency one cycle from the accepting edge; empty and st_ready SHALL follow count.

Reset
REQ-035 SHALL, on reset low, immediately clear pointers, count and all entry valid bits regardless of clk.
REQ-036 SHALL drive during and after reset: count 0, empty 1, st_ready 1, mem_req 0, mem_addr/mem_wdata/mem_byteen 0, ld_hit 0.
REQ-037 SHALL discard in-flight entries on reset mid-operation; a mem_ack in the first cycle after release SHALL be ignored.

Verification
REQ-038 SHALL test byte store: addr 0x1003, size 00, wdata 0x000000AB -> next cycle mem_req 1, mem_addr 0x1000, byteen 1000, wdata 0xABABABAB.
REQ-039 SHALL test misaligned store: half to 0x2001 -> st_exc 1, count stays 0; word to 0x2002 -> st_exc 1; size 11 -> st_exc 1.
REQ-040 SHALL test fill with mem_ack 0: DEPTH=4, 5 word stores -> st_ready 0 after 4th, 5th not accepted, count 4; then drain via acks in the original order.
REQ-041 SHALL test simultaneous events: count 2, enqueue + ack in the same cycle -> count 2, head advances to the 2nd entry.
REQ-042 SHALL test hazard: pending half store at 0x3002, ld_addr 0x3000 -> ld_hit 1; ld_addr 0x3004 -> ld_hit 0; after its ack -> ld_hit 0.
REQ-043 SHALL test reset mid-operation: count 3, assert reset between edges -> outputs immediately at REQ-036 values; after release the first store is accepted normally.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order CPU store buffer. Stores that pass the alignment check are
// converted into word-aligned memory writes (lane-replicated data plus byte
// enables) and queued in a small circular FIFO. The head entry is presented
// to memory until acknowledged. A load-address probe reports whether any
// queued store targets the same 32-bit word.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset
//   st_valid   : store request from the CPU
//   st_ready   : buffer has room for a store (count != DEPTH)
//   st_addr    : store byte address
//   st_size    : 00 byte, 01 half, 10 word, 11 reserved
//   st_wdata   : store data, right-justified
//   st_exc     : current store request is misaligned or has a reserved size
//   mem_req    : head entry is valid toward memory
//   mem_addr   : head word address (low two bits always zero)
//   mem_wdata  : head lane-replicated write data
//   mem_byteen : head byte enables, bit i = byte lane i
//   mem_ack    : memory accepted the head entry
//   ld_addr    : load address for the hazard check
//   ld_hit     : a queued store targets the word holding ld_addr
//   count      : number of occupied entries
//   empty      : count == 0
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [1:0]               st_size,
  input  logic [31:0]              st_wdata,
  output logic                     st_exc,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byteen,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;  // word-address width

  // Entry storage. Only the valid bits need reset; payload is qualified by them.
  logic [WW-1:0]    addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [3:0]       be_mem   [DEPTH];
  logic [DEPTH-1:0] valid_reg;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  logic       misaligned;
  logic       enq;
  logic       deq;
  logic       full;
  logic [3:0] new_be;
  logic [31:0] new_data;
  logic [DEPTH-1:0] hit_vec;

  // ---------------------------------------------------------------------------
  // Store request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    misaligned = 1'b0;
    unique case (st_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = st_addr[0];
      2'b10:   misaligned = |st_addr[1:0];
      default: misaligned = 1'b1;  // reserved size always faults
    endcase
  end

  assign st_exc = st_valid & misaligned;

  always_comb begin
    new_be   = 4'b1111;
    new_data = st_wdata;
    unique case (st_size)
      2'b00: begin
        new_be   = 4'b0001 << st_addr[1:0];
        new_data = {4{st_wdata[7:0]}};
      end
      2'b01: begin
        new_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        new_data = {2{st_wdata[15:0]}};
      end
      default: begin
        new_be   = 4'b1111;
        new_data = st_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Occupancy and handshakes. Full blocks enqueue even when the head is
  // leaving in the same cycle; readiness depends only on count.
  // ---------------------------------------------------------------------------
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign st_ready = ~full;
  assign count    = count_reg;
  assign mem_req  = ~empty;

  assign enq = st_valid & st_ready & ~st_exc;
  assign deq = mem_req & mem_ack;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (enq) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;  // DEPTH is a power of two: natural wrap
    end
    if (deq) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    unique case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload write port
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= st_addr[ADDR_W-1:2];
      data_mem[wr_ptr_reg] <= new_data;
      be_mem[wr_ptr_reg]   <= new_be;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry valid bits and hazard compare. An entry being written this cycle
  // is not yet valid, so it never hits; the entry leaving this cycle still does.
  // Enqueue and dequeue can never target the same slot in one cycle: equal
  // pointers while not full means empty, which blocks dequeue.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic valid_next;

    always_comb begin
      valid_next = valid_reg[gi];
      if (enq && (wr_ptr_reg == PW'(gi))) begin
        valid_next = 1'b1;
      end else if (deq && (rd_ptr_reg == PW'(gi))) begin
        valid_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_reg[gi] <= 1'b0;
      end else begin
        valid_reg[gi] <= valid_next;
      end
    end

    assign hit_vec[gi] = valid_reg[gi] && (addr_mem[gi] == ld_addr[ADDR_W-1:2]);
  end

  assign ld_hit = |hit_vec;

  // ---------------------------------------------------------------------------
  // Head outputs, forced to zero while empty so reset clears them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteen = '0;
    if (!empty) begin
      mem_addr   = {addr_mem[rd_ptr_reg], 2'b00};
      mem_wdata  = data_mem[rd_ptr_reg];
      mem_byteen = be_mem[rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [1:0]        st_size;
  logic [31:0]       st_wdata;
  logic              st_exc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              mem_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [CW-1:0]     count;
  logic              empty;

  int checks = 0;
  int errors = 0;

  store_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_size(st_size), .st_wdata(st_wdata), .st_exc(st_exc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byteen(mem_byteen), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending memory writes.
  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  function automatic logic m_exc(logic v, logic [1:0] sz, logic [31:0] a);
    int lo;
    lo = int'(a) % 4;
    if (!v) return 1'b0;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (lo % 2) != 0;
    if (sz == 2'd2) return lo != 0;
    return 1'b0;
  endfunction

  function automatic ent_t m_entry(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    ent_t e;
    int lo;
    lo      = int'(a & 32'd3);
    e.waddr = a - 32'(lo);
    if (sz == 2'd0) begin
      e.be   = 4'(1 << lo);
      e.data = (d & 32'hFF) * 32'h01010101;
    end else if (sz == 2'd1) begin
      e.be   = (lo >= 2) ? 4'hC : 4'h3;
      e.data = (d & 32'hFFFF) * 32'h00010001;
    end else begin
      e.be   = 4'hF;
      e.data = d;
    end
    return e;
  endfunction

  function automatic logic m_hit(logic [31:0] la);
    foreach (q[i]) if (q[i].waddr == (la & ~32'd3)) return 1'b1;
    return 1'b0;
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    logic enq, deq;
    ent_t e;
    enq = st_valid && (q.size() < DEPTH) && !m_exc(st_valid, st_size, st_addr);
    deq = mem_ack && (q.size() > 0);
    e   = m_entry(st_size, st_addr, st_wdata);
    @(posedge clk);
    #1;
    if (deq) q.delete(0);
    if (enq) q.push_back(e);
  endtask

  task automatic idle();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_wdata = d;
  endtask

  task automatic drain();
    idle();
    mem_ack = 1'b1;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) tick();
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    st_addr = '0; st_size = '0; st_wdata = '0; ld_addr = '0;
    #2;
    checks++;
    if ({count, empty, st_ready, mem_req, ld_hit} !== {CW'(0), 4'b1100}) begin
      errors++;
      $display("FAIL reset_status: got count=%0d empty=%b ready=%b req=%b hit=%b want 0 1 1 0 0",
               count, empty, st_ready, mem_req, ld_hit);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_addr, mem_wdata, mem_byteen} !== 68'h0) begin
      errors++;
      $display("FAIL reset_head: got addr=%h data=%h be=%b want zeros", mem_addr, mem_wdata, mem_byteen);
    end
    reset = 1'b1;
    q.delete();
    #1;
    checks++;
    if (empty !== 1'b1 || count !== CW'(0)) begin
      errors++;
      $display("FAIL reset_release: got empty=%b count=%0d want 1 0", empty, count);
    end
    $display("test_reset done");
  endtask

  task automatic test_byte_store();
    store(2'b00, 32'h1003, 32'h000000AB);
    #1;
    checks++;
    if (st_exc !== 1'b0) begin
      errors++;
      $display("FAIL byte_exc: got %b want 0", st_exc);
    end
    tick();
    idle();
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_byteen, mem_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hABABABAB}) begin
      errors++;
      $display("FAIL byte_head: got req=%b addr=%h be=%b data=%h want 1 00001000 1000 abababab",
               mem_req, mem_addr, mem_byteen, mem_wdata);
    end
    checks++;
    if (count !== CW'(1)) begin
      errors++;
      $display("FAIL byte_count: got %0d want 1", count);
    end
    drain();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL byte_drain: got empty=%b want 1", empty);
    end
    $display("test_byte_store: addr=1003 size=0 -> be=1000 data=abababab");
  endtask

  task automatic test_misaligned();
    store(2'b01, 32'h2001, 32'h1234);
    #1;
    checks++;
    if (st_exc !== 1'b1) begin
      errors++;
      $display("FAIL mis_half_exc: got %b want 1", st_exc);
    end
    tick();
    checks++;
    if (count !== CW'(0)) begin
      errors++;
      $display("FAIL mis_half_count: got %0d want 0", count);
    end
    store(2'b10, 32'h2002, 32'h5678);
    #1;
    checks++;
    if (st_exc !== 1'b1) begin
      errors++;
      $display("FAIL mis_word_exc: got %b want 1", st_exc);
    end
    tick();
    store(2'b11, 32'h2000, 32'h9);
    #1;
    checks++;
    if (st_exc !== 1'b1) begin
      errors++;
      $display("FAIL mis_rsvd_exc: got %b want 1", st_exc);
    end
    tick();
    checks++;
    if (count !== CW'(0)) begin
      errors++;
      $display("FAIL mis_count: got %0d want 0", count);
    end
    st_valid = 1'b0;
    #1;
    checks++;
    if (st_exc !== 1'b0) begin
      errors++;
      $display("FAIL mis_novalid_exc: got %b want 0", st_exc);
    end
    $display("test_misaligned: half@2001 word@2002 size11 all faulted");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      store(2'b10, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      #1;
      checks++;
      if (st_ready !== (i < 4)) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want %b", i, st_ready, (i < 4));
      end
      tick();
    end
    idle();
    checks++;
    if (count !== CW'(4)) begin
      errors++;
      $display("FAIL fill_count: got %0d want 4", count);
    end
    // Full with a dequeue in the same cycle: the store must still be refused.
    store(2'b10, 32'h200, 32'hDEAD);
    mem_ack = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL fill_nobypass: got count=%0d want 3", count);
    end
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (mem_addr !== 32'h100 + 32'(4 * i) || mem_wdata !== 32'hC0DE0000 + 32'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: got addr=%h data=%h want %h %h", i, mem_addr, mem_wdata,
                 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      end
      mem_ack = 1'b1;
      tick();
    end
    idle();
    checks++;
    if (empty !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b req=%b want 1 0", empty, mem_req);
    end
    $display("test_fill_drain: 5th store refused, drained in order");
  endtask

  task automatic test_simultaneous();
    store(2'b10, 32'h400, 32'hA); tick();
    store(2'b10, 32'h404, 32'hB); tick();
    store(2'b10, 32'h408, 32'hC);
    mem_ack = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== CW'(2) || mem_addr !== 32'h404) begin
      errors++;
      $display("FAIL simul: got count=%0d head=%h want 2 00000404", count, mem_addr);
    end
    drain();
    $display("test_simultaneous: enq+ack keeps count 2, head -> 404");
  endtask

  task automatic test_hazard();
    // Entry being written this cycle does not hit.
    store(2'b01, 32'h3002, 32'h1234);
    ld_addr = 32'h3000;
    #1;
    checks++;
    if (ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL haz_enq_excl: got %b want 0", ld_hit);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ld_hit !== 1'b1 || mem_byteen !== 4'b1100 || mem_wdata !== 32'h12341234) begin
      errors++;
      $display("FAIL haz_hit: got hit=%b be=%b data=%h want 1 1100 12341234", ld_hit, mem_byteen, mem_wdata);
    end
    ld_addr = 32'h3004;
    #1;
    checks++;
    if (ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL haz_other_word: got %b want 0", ld_hit);
    end
    ld_addr = 32'h3000;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ld_hit !== 1'b1) begin
      errors++;
      $display("FAIL haz_deq_incl: got %b want 1", ld_hit);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ld_hit !== 1'b0) begin
      errors++;
      $display("FAIL haz_after_ack: got %b want 0", ld_hit);
    end
    $display("test_hazard: half@3002 hits 3000, not 3004, clears after ack");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      store(2'b10, 32'h500 + 32'(4 * i), 32'(i));
      tick();
    end
    idle();
    ld_addr = 32'h500;
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL rmid_pre: got count=%0d want 3", count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({count, empty, st_ready, mem_req, ld_hit} !== {CW'(0), 4'b1100} ||
        {mem_addr, mem_wdata, mem_byteen} !== 68'h0) begin
      errors++;
      $display("FAIL rmid_async: got count=%0d empty=%b ready=%b req=%b hit=%b addr=%h want 0 1 1 0 0 0",
               count, empty, st_ready, mem_req, ld_hit, mem_addr);
    end
    q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    // First cycle after release: ack ignored, store accepted.
    store(2'b10, 32'h600, 32'hFEED);
    mem_ack = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== CW'(1) || mem_addr !== 32'h600 || mem_wdata !== 32'hFEED) begin
      errors++;
      $display("FAIL rmid_post: got count=%0d addr=%h data=%h want 1 00000600 0000feed",
               count, mem_addr, mem_wdata);
    end
    drain();
    $display("test_reset_mid: reset cleared 3 entries, next store accepted");
  endtask

  task automatic test_random();
    ent_t h;
    int bad;
    for (int n = 0; n < 400; n++) begin
      st_valid = ($urandom_range(0, 3) != 0);
      st_size  = 2'($urandom_range(0, 3));
      st_addr  = 32'h7000 + 32'($urandom_range(0, 31));
      st_wdata = $urandom;
      mem_ack  = ($urandom_range(0, 2) == 0);
      ld_addr  = 32'h7000 + 32'($urandom_range(0, 31));
      #1;
      h   = (q.size() > 0) ? q[0] : '0;
      bad = 0;
      checks++;
      if (st_exc !== m_exc(st_valid, st_size, st_addr)) begin
        bad++;
        $display("FAIL rnd_exc[%0d]: got %b want %b", n, st_exc, m_exc(st_valid, st_size, st_addr));
      end
      checks++;
      if (count !== CW'(q.size()) || empty !== (q.size() == 0) ||
          st_ready !== (q.size() != DEPTH) || mem_req !== (q.size() != 0)) begin
        bad++;
        $display("FAIL rnd_status[%0d]: got count=%0d empty=%b ready=%b req=%b want count=%0d",
                 n, count, empty, st_ready, mem_req, q.size());
      end
      checks++;
      if (mem_addr !== h.waddr || mem_wdata !== h.data || mem_byteen !== h.be) begin
        bad++;
        $display("FAIL rnd_head[%0d]: got %h %h %b want %h %h %b",
                 n, mem_addr, mem_wdata, mem_byteen, h.waddr, h.data, h.be);
      end
      checks++;
      if (ld_hit !== m_hit(ld_addr)) begin
        bad++;
        $display("FAIL rnd_hit[%0d]: got %b want %b", n, ld_hit, m_hit(ld_addr));
      end
      errors += bad;
      tick();
    end
    drain();
    $display("test_random: 400 random cycles compared");
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_misaligned();
    test_fill_drain();
    test_simultaneous();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
